// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: memory geometry, RISC-V funct3
// encodings, FSM states and the access-legality rule.
package load_store_unit_pkg;

  localparam int INST_SIZE = 32;
  localparam int MEM_SIZE  = 1024;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } lsu_state_e;

  // True when the access is misaligned or its funct3 is not legal for its direction.
  function automatic logic lsu_bad_access(input logic       store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
    logic legal;
    case (funct3)
      LSU_B:   legal = 1'b1;
      LSU_H:   legal = !offset[0];
      LSU_W:   legal = (offset == 2'b00);
      LSU_BU:  legal = !store;
      LSU_HU:  legal = !store && !offset[0];
      default: legal = 1'b0;
    endcase
    return !legal;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word_i[{offset_i, 3'b000} +: 8];
  assign half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    // NOTE: both outputs get a default first so no path can infer a latch.
    load_data_o = word_i;
    merged_o    = word_i;
    case (funct3_i)
      LSU_B: begin
        load_data_o = {{24{byte_lane[7]}}, byte_lane};
        merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      LSU_H: begin
        load_data_o = {{16{half_lane[15]}}, half_lane};
        merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i;
      end
      LSU_BU:  load_data_o = {24'h0, byte_lane};
      LSU_HU:  load_data_o = {16'h0, half_lane};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator for a word-addressed data memory.
// Optional LSU_PERF_CNT_EN adds load/store/misalign event counters.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = INST_SIZE,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misaligned,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt,
  output logic [31:0]       misalign_cnt
`endif
);

  lsu_state_e        state_q;
  logic [2:0]        funct3_q;
  logic [1:0]        offset_q;
  logic [15:0]       wdata_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_misaligned_q;
  logic              mem_we_q;
  logic [IDX_W-1:0]  mem_a_q;
  logic [DATA_W-1:0] mem_wd_q;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];

  lsu_lane_align u_lane_align (
    .funct3_i    (funct3_q),
    .offset_i    (offset_q),
    .word_i      (mem_rd),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= ST_IDLE;
      funct3_q          <= 3'b000;
      offset_q          <= 2'b00;
      wdata_q           <= '0;
      resp_valid_q      <= 1'b0;
      resp_rdata_q      <= '0;
      resp_misaligned_q <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_a_q           <= '0;
      mem_wd_q          <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update
      // sees the values from before this edge.
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            offset_q <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            if (lsu_bad_access(req_store, req_funct3, req_addr[1:0])) begin
              resp_valid_q      <= 1'b1;
              resp_rdata_q      <= '0;
              resp_misaligned_q <= 1'b1;
              state_q           <= ST_RESP;
            end else begin
              mem_a_q <= req_addr[IDX_W+1:2];
              if (!req_store) begin
                state_q <= ST_LOAD;
              end else if (req_funct3 == LSU_W) begin
                mem_we_q <= 1'b1;
                mem_wd_q <= req_wdata;
                state_q  <= ST_STORE;
              end else begin
                state_q <= ST_RMW_RD;
              end
            end
          end
        end
        ST_LOAD: begin
          resp_valid_q      <= 1'b1;
          resp_rdata_q      <= load_data;
          resp_misaligned_q <= 1'b0;
          state_q           <= ST_RESP;
        end
        ST_RMW_RD: begin
          // mem_wd_q doubles as the merge register for the read-modify-write.
          mem_wd_q <= merged;
          mem_we_q <= 1'b1;
          state_q  <= ST_RMW_WR;
        end
        ST_STORE, ST_RMW_WR: begin
          mem_we_q          <= 1'b0;
          resp_valid_q      <= 1'b1;
          resp_rdata_q      <= '0;
          resp_misaligned_q <= 1'b0;
          state_q           <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready       = (state_q == ST_IDLE);
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_misaligned_q;
  assign mem_a           = mem_a_q;
  assign mem_wd          = mem_wd_q;
  // Reset asserted during a write cycle suppresses that write at the same edge.
  assign mem_we          = mem_we_q & rst;

`ifdef LSU_PERF_CNT_EN
  logic        store_q;
  logic [31:0] load_cnt_q;
  logic [31:0] store_cnt_q;
  logic [31:0] misalign_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      store_q        <= 1'b0;
      load_cnt_q     <= '0;
      store_cnt_q    <= '0;
      misalign_cnt_q <= '0;
    end else begin
      if (state_q == ST_IDLE && req_valid) store_q <= req_store;
      if (state_q == ST_RESP) begin
        if (resp_misaligned_q) misalign_cnt_q <= misalign_cnt_q + 32'd1;
        else if (store_q)      store_cnt_q    <= store_cnt_q + 32'd1;
        else                   load_cnt_q     <= load_cnt_q + 32'd1;
      end
    end
  end

  assign load_cnt     = load_cnt_q;
  assign store_cnt    = store_cnt_q;
  assign misalign_cnt = misalign_cnt_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: reference memory plus scoreboard of
// expected responses, checked by one compare process every falling edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_misaligned, mem_we;
  logic [31:0] resp_rdata, mem_wd, mem_rd;
  logic [9:0]  mem_a;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] load_cnt, store_cnt, misalign_cnt;
`endif

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef LSU_PERF_CNT_EN
    , .load_cnt(load_cnt), .store_cnt(store_cnt), .misalign_cnt(misalign_cnt)
`endif
  );

  // Environment memory (not a model): combinational read, posedge write.
  logic [31:0] mem [0:1023];
  logic        fill_en = 1'b1;
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  assign mem_rd = mem[mem_a];

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (mem_we) begin
      mem[mem_a] <= mem_wd;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end
  end

  // Reference model state and scoreboard.
  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          due;
  } exp_t;

  logic [31:0] ref_mem [0:1023];
  exp_t        q[$];
  bit          expect_busy = 1'b0;
  int          ncyc = 0;
  int          we_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_ld = 0, n_st = 0, n_mis = 0;
  logic [31:0] last_rdata = '0;
  logic        last_mis = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Spec-level model: byte-address arithmetic with shifts and masks.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rdata,
                                output bit mis, output int lat, output int writes);
    int          idx = int'(addr[11:2]);
    int          sh = 8 * int'(addr[1:0]);
    int          size;
    bit          sgn;
    bit          legal;
    logic [31:0] mask, val;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    sgn   = (f3[2] == 1'b0) && (size < 4);
    legal = st ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (!legal || (int'(addr[1:0]) % size) != 0) begin
      rdata = 0; mis = 1; lat = 1; writes = 0;
      return;
    end
    mis  = 0;
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
    if (!st) begin
      val = (ref_mem[idx] >> sh) & mask;
      if (sgn && val[8*size-1]) val = val | ~mask;
      rdata = val; lat = 2; writes = 0;
    end else begin
      ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
      rdata = 0; lat = (size == 4) ? 2 : 3; writes = 1;
    end
  endfunction

  // Compare process: the single place DUT outputs meet the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        check("req_ready", {31'b0, req_ready}, {31'b0, !expect_busy});
        if (mem_we) we_cnt++;
        if (resp_valid) begin
          if (q.size() == 0) begin
            check("unexpected_resp", {31'b0, resp_valid}, 32'd0);
          end else begin
            e = q.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_misaligned", {31'b0, resp_misaligned}, {31'b0, e.mis});
            check("resp_cycle", ncyc, e.due);
            last_rdata  = resp_rdata;
            last_mis    = resp_misaligned;
            expect_busy = 1'b0;
          end
        end else if (q.size() != 0 && ncyc > q[0].due) begin
          check("resp_late", {31'b0, resp_valid}, 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_idx = idx[9:0];
    poke_val = val;
    poke_en  = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    exp_t e;
    bit   mis;
    int   lat, writes;
    int   idx = int'(addr[11:2]);
    @(negedge clk);
    req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check("ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    model(st, f3, addr, wd, e.rdata, mis, lat, writes);
    e.mis = mis;
    e.due = ncyc + lat;
    q.push_back(e);
    expect_busy = 1'b1;
    we_cnt = 0;
    if (mis) n_mis++; else if (st) n_st++; else n_ld++;
    #1 req_valid = 1'b0;
    for (int i = 0; i < 12 && expect_busy; i++) @(negedge clk);
    check("resp_timeout", {31'b0, expect_busy}, 32'd0);
    if (expect_busy) begin
      q.delete();
      expect_busy = 1'b0;
    end
    check("mem_we_cycles", we_cnt, writes);
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h1000_0000 + i;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 fill_en = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_mis", {31'b0, resp_misaligned}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_a", {22'b0, mem_a}, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Word load and index wrap.
    poke(5, 32'h8899AABB);
    do_op(1'b0, 3'b010, 32'h0000_0014, 32'h0);
    check("lw_lit", last_rdata, 32'h8899AABB);
    do_op(1'b0, 3'b010, 32'h0000_1014, 32'h0);
    check("lw_wrap_lit", last_rdata, 32'h8899AABB);
    do_op(1'b0, 3'b000, 32'h0000_0017, 32'h0);
    check("lb_top_lit", last_rdata, 32'hFFFFFF88);

    // Sign/zero extension.
    poke(0, 32'h000080FF);
    do_op(1'b0, 3'b000, 32'h1, 32'h0);
    check("lb_sign_lit", last_rdata, 32'hFFFFFF80);
    do_op(1'b0, 3'b100, 32'h1, 32'h0);
    check("lbu_lit", last_rdata, 32'h00000080);
    do_op(1'b0, 3'b001, 32'h0, 32'h0);
    check("lh_lit", last_rdata, 32'hFFFF80FF);
    do_op(1'b0, 3'b101, 32'h2, 32'h0);
    check("lhu_hi_lit", last_rdata, 32'h00000000);

    // Sub-word stores (read-modify-write).
    poke(2, 32'h11223344);
    do_op(1'b1, 3'b001, 32'hA, 32'hDEADBEEF);
    check("sh_mem_lit", mem[2], 32'hBEEF3344);
    do_op(1'b1, 3'b000, 32'h9, 32'h00000055);
    check("sb_mem_lit", mem[2], 32'hBEEF5544);

    // Misaligned and illegal accesses.
    do_op(1'b0, 3'b010, 32'h6, 32'h0);
    check("lw_mis_lit", {31'b0, last_mis}, 32'd1);
    do_op(1'b0, 3'b001, 32'h3, 32'h0);
    do_op(1'b0, 3'b101, 32'h1, 32'h0);
    do_op(1'b0, 3'b011, 32'h0, 32'h0);
    do_op(1'b0, 3'b111, 32'h8, 32'h0);
    do_op(1'b1, 3'b100, 32'h8, 32'h12345678);
    do_op(1'b1, 3'b010, 32'h2, 32'h12345678);
    check("mis_mem_lit", mem[0], 32'h000080FF);

    // Reset in the middle of a read-modify-write.
    poke(3, 32'h01020304);
    @(negedge clk);
    req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'hD; req_wdata = 32'hAA;
    req_valid = 1'b1;
    @(posedge clk);
    expect_busy = 1'b1;
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rmw_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rmw_rst_rdata", resp_rdata, 32'd0);
    check("rmw_rst_mis", {31'b0, resp_misaligned}, 32'd0);
    check("rmw_rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rmw_rst_mem_a", {22'b0, mem_a}, 32'd0);
    check("rmw_rst_mem_wd", mem_wd, 32'd0);
    check("rmw_rst_mem_lit", mem[3], 32'h01020304);
    expect_busy = 1'b0;
    n_ld = 0; n_st = 0; n_mis = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rmw_rst_ready", {31'b0, req_ready}, 32'd1);

    // Back-to-back word store then load.
    do_op(1'b1, 3'b010, 32'h4, 32'hCAFEF00D);
    check("sw_mem_lit", mem[1], 32'hCAFEF00D);
    do_op(1'b0, 3'b010, 32'h4, 32'h0);
    check("lw_after_sw_lit", last_rdata, 32'hCAFEF00D);
    do_op(1'b1, 3'b000, 32'h7, 32'h0000_0099);
    do_op(1'b0, 3'b100, 32'h7, 32'h0);
    check("lbu_after_sb_lit", last_rdata, 32'h00000099);

`ifdef LSU_PERF_CNT_EN
    @(negedge clk);
    check("load_cnt", load_cnt, n_ld);
    check("store_cnt", store_cnt, n_st);
    check("misalign_cnt", misalign_cnt, n_mis);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage initiator that drives the word-addressed data memory on behalf of the pipeline.
- Accepts one load or store request at a time through a valid/ready handshake.
- Converts byte addresses to word indices and performs read-modify-write for byte and halfword stores.
- Extracts and extends loaded data, then returns one response per request.

Parameters:
ADDR_W, 32, byte-address width from the pipeline
DATA_W, 32, data width; must equal `INST_SIZE (32)
IDX_W, 10, word-index width driven to memory (memory depth 2^IDX_W words)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_store  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data (low bits used for B/H)
resp_valid  out  1  one-cycle pulse, response ready
resp_rdata  out  DATA_W  extended load data; 0 for stores
resp_misaligned  out  1  access was misaligned or funct3 was illegal; no memory access made
mem_we  out  1  memory write enable
mem_a  out  IDX_W  word index = addr[IDX_W+1:2]
mem_wd  out  DATA_W  memory write data
mem_rd  in  DATA_W  memory read data (combinational from mem_a)

Behaviour:
- Reset (rst==0 at posedge): state IDLE; resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_we=0, mem_a=0, mem_wd=0; all request registers cleared. Reset wins over everything, including mid-operation: a pending RMW write is abandoned and never issued.
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready=1. On req_valid, latch store, funct3, addr and wdata, then check legality:
  - Misaligned is H/HU with addr[0]=1, or W with addr[1:0]!=0. Illegal funct3 is 011, 110 or 111 for loads, and anything other than 000/001/010 for stores.
  - Illegal or misaligned -> RESP with misaligned=1.
  - Load -> LOAD.
  - Word store -> STORE.
  - Byte/half store -> RMW_RD.
- LOAD: drive mem_a; capture mem_rd. Select the lane by addr[1:0] (byte) or addr[1] (half). Sign-extend for B/H, zero-extend for BU/HU, pass through for W. -> RESP.
- STORE: mem_we=1, mem_wd=wdata for exactly this cycle. -> RESP.
- RMW_RD: drive mem_a; capture mem_rd into the merge register. -> RMW_WR.
- RMW_WR: mem_we=1. mem_wd is the captured word with the target byte/half lane replaced by wdata[7:0] or wdata[15:0]. -> RESP.
- RESP: resp_valid=1 for exactly one cycle; outputs hold the computed values. -> IDLE.
- Latency from accept edge to resp_valid:
  - Load and word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Misaligned/illegal: 1 cycle.
- Throughput: at most one request in flight. req_valid is ignored outside IDLE, and the requester must hold it until accepted.
- Outside the write states, mem_we=0 and mem_wd holds its last value.
- resp_rdata and resp_misaligned are registered. They keep their values until the next RESP or reset, but are only meaningful while resp_valid=1.
- Address bits above IDX_W+1 are ignored, so the index wraps modulo memory depth.

Optional Feature:
LSU_PERF_CNT_EN:
- Defined: adds output ports load_cnt[31:0], store_cnt[31:0] and misalign_cnt[31:0], each incremented in the RESP cycle of the matching request type. All three clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared constants header (alongside `INST_SIZE/`MEM_SIZE): funct3 encodings LSU_B/H/W/BU/HU and FSM state encodings.
- One sub-module, lsu_lane_align: combinational load extract/extend and store lane merge, shared by LOAD and RMW_WR.

Test Plan:
- Word load: mem[5]=0x8899AABB; LW addr 0x14 -> resp_rdata=0x8899AABB, misaligned=0, resp_valid 2 cycles after accept.
- Sign/zero byte: mem[0]=0x000080FF; LB addr 0x1 -> 0xFFFFFF80; LBU addr 0x1 -> 0x00000080.
- Sub-word store RMW: mem[2]=0x11223344; SH addr 0xA, wdata 0xDEADBEEF -> mem[2]=0xBEEF3344, mem_we high for exactly one cycle, resp in 3 cycles.
- Misaligned: LW addr 0x6 -> resp_misaligned=1 in 1 cycle, mem_we never asserted, memory unchanged.
- Reset mid-RMW: SB issued, rst=0 during RMW_WR -> no write occurs, outputs zero, req_ready=1 after release.
- Back-to-back: SW 0x4 = 0xCAFEF00D, then LW 0x4 immediately after resp -> 0xCAFEF00D; req_ready=0 while busy.
